upct_update_ctrl: RTL and testbench
===================================

# upct_update_ctrl

Arbitration and sequencing front-end for the Upper PC Table (UPCT) update port. It accepts upper-PC install requests from NUM_REQ requesters (e.g. decode-side and branch-resolution paths) with round-robin arbitration and queues them in a small FIFO. It issues at most one request per cycle on the UPCT update0 port, inserts a bubble where two back-to-back issues would allocate duplicate entries, and returns the UPCT index from update1 to the originating requester.

## Interface
- NUM_REQ, 2, number of requesters (power of 2, ≥2)
- FIFO_DEPTH, 4, request queue entries (power of 2, ≥2)
- UPPER_PC_WIDTH, LOG_UPCT_ENTRIES: package constants (core_types_pkg), not overridable here
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  per-requester request
- req_start_full_PC  in  NUM_REQ×32  per-requester full PC
- req_ready  out  NUM_REQ  one-hot grant; request accepted when req_valid[i] & req_ready[i]
- flush  in  1  drop all queued and in-flight requests
- update0_valid  out  1  to UPCT update0_valid
- update0_start_full_PC  out  32  to UPCT; {upper_PC, zeros}
- update1_upct_index  in  LOG_UPCT_ENTRIES  from UPCT, valid the cycle after an issue
- resp_valid  out  1  response for an issued request
- resp_req_id  out  log2(NUM_REQ)  originating requester
- resp_upper_PC  out  UPPER_PC_WIDTH  upper PC of that request
- resp_upct_index  out  LOG_UPCT_ENTRIES  UPCT entry holding resp_upper_PC

## Operation
- Upper PC = start_full_PC[31:32-UPPER_PC_WIDTH]; only this field and the requester ID are stored.
- Arbiter: round-robin pointer rr_ptr. The grant goes to the first i with req_valid[i], scanning from rr_ptr upward with wrap.
- A grant is given only if the registered FIFO count < FIFO_DEPTH and flush=0. Full is not relaxed by a same-cycle dequeue.
- On a grant to i: rr_ptr ← i+1 mod NUM_REQ. With no grant, rr_ptr holds.
- req_ready is combinational from req_valid, count and rr_ptr. At most one bit is set.
- FIFO: circular buffer with head/tail pointers wrapping at FIFO_DEPTH and count 0..FIFO_DEPTH. Enqueue and dequeue in the same cycle leave count unchanged.
- Issue stage: if the FIFO is non-empty, flush=0, and no hazard, dequeue the head, drive update0_valid=1 and update0_start_full_PC={head.upper_PC, 0}. Capture {id, upper_PC} into the in-flight register s1 (s1_valid=1).
- Hazard: if s1_valid and head.upper_PC == s1.upper_PC, do not issue that cycle (bubble); s1_valid then clears. The next cycle issues the head, and the UPCT CAM hits the entry written by the earlier issue.
- Response: when s1_valid=1 the outputs are resp_valid=1, resp_req_id=s1.id, resp_upper_PC=s1.upper_PC, resp_upct_index=update1_upct_index. These are combinational from s1 and the UPCT.
- Flush: FIFO cleared (head=tail=count=0), s1_valid←0, resp_valid forced 0 in the flush cycle. No grant and no issue in the flush cycle. rr_ptr holds.
- A request already presented to UPCT update0 still completes inside UPCT. Only its response is suppressed.

## Timing
- Reset values: rr_ptr=0, count=0, head=tail=0, s1_valid=0. Outputs: req_ready=0 (until req_valid), update0_valid=0, update0_start_full_PC=0, resp_valid=0, resp_req_id=0, resp_upper_PC=0, resp_upct_index passes UPCT index.
- Accept at cycle N → earliest issue N+1 (no FIFO bypass) → resp_valid at N+2.
- Hazard bubble adds exactly 1 cycle. Throughput is 1 issue/cycle otherwise.
- Responses return in issue (FIFO) order. No response backpressure: requesters must sink resp_valid every cycle.
- Reset mid-operation discards all state asynchronously. The next accepted request after release behaves as the first.
- A flush coinciding with a req_valid: the request is not accepted (req_ready=0) and the requester retries.

## Test plan
- Single request: req0 PC=0x8000_1000 at cycle 1 → update0_valid at 2 with matching upper bits; resp_valid at 3, resp_req_id=0, resp_upct_index=UPCT index.
- RR fairness: req0 and req1 valid every cycle from reset → grants alternate 0,1,0,1; rr_ptr=0 after the 4th grant.
- Backpressure: FIFO_DEPTH=4, hold issue off via repeated hazard-free enqueues with no drain impossible; instead fill 4 at reset with UPCT stubbed. Check that req_ready=0 while count=4 and that count never exceeds 4.
- Hazard: two requests with the same upper PC queued back to back → issues at N and N+2 (bubble at N+1); both responses carry the same resp_upct_index and one UPCT entry is allocated.
- Flush: 3 queued, 1 in s1, flush=1 → resp_valid=0 that cycle; count=0 next cycle; no further update0_valid until new requests.
- Reset mid-stream: nRST low with count=2, s1_valid=1 → all outputs at reset values immediately; after release the first grant goes to req0.

Source files
------------

// File: rtl/upct_update_ctrl.sv
// UPCT update-port front end: round-robin arbitration of upper-PC install requests, a small
// request FIFO, duplicate-allocation bubble and response return to the originating requester.

package core_types_pkg;
    parameter int unsigned UPPER_PC_WIDTH   = 22;
    parameter int unsigned LOG_UPCT_ENTRIES = 3;
endpackage

module upct_update_ctrl
    import core_types_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                              CLK,
    input  logic                              nRST,

    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ-1:0][31:0]          req_start_full_PC,
    output logic [NUM_REQ-1:0]                req_ready,

    input  logic                              flush,

    output logic                              update0_valid,
    output logic [31:0]                       update0_start_full_PC,
    input  logic [LOG_UPCT_ENTRIES-1:0]       update1_upct_index,

    output logic                              resp_valid,
    output logic [ID_W-1:0]                   resp_req_id,
    output logic [UPPER_PC_WIDTH-1:0]         resp_upper_PC,
    output logic [LOG_UPCT_ENTRIES-1:0]       resp_upct_index
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned LOW_W = 32 - UPPER_PC_WIDTH;

    logic [ID_W-1:0]           rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]          head_q, head_d;
    logic [PTR_W-1:0]          tail_q, tail_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic [ID_W-1:0]           fifo_id_q  [FIFO_DEPTH];
    logic [UPPER_PC_WIDTH-1:0] fifo_upc_q [FIFO_DEPTH];

    logic                      s1_valid_q, s1_valid_d;
    logic [ID_W-1:0]           s1_id_q, s1_id_d;
    logic [UPPER_PC_WIDTH-1:0] s1_upc_q, s1_upc_d;

    logic                      grant_valid;
    logic [ID_W-1:0]           grant_id;
    logic [ID_W-1:0]           scan_idx;
    logic [UPPER_PC_WIDTH-1:0] grant_upc;
    logic [UPPER_PC_WIDTH-1:0] head_upc;
    logic [ID_W-1:0]           head_id;
    logic                      hazard;
    logic                      issue;

    // Only the upper field is stored; the low PC bits are intentionally dropped.
    logic unused_pc_bits;
    assign unused_pc_bits = ^req_start_full_PC;

    always_comb begin
        req_ready   = '0;
        grant_valid = 1'b0;
        grant_id    = '0;
        scan_idx    = '0;
        if ((count_q < CNT_W'(FIFO_DEPTH)) && !flush) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                scan_idx = rr_ptr_q + ID_W'(k);
                if (!grant_valid && req_valid[scan_idx]) begin
                    grant_valid = 1'b1;
                    grant_id    = scan_idx;
                end
            end
        end
        if (grant_valid) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign grant_upc = req_start_full_PC[grant_id][31 -: UPPER_PC_WIDTH];
    assign head_upc  = fifo_upc_q[head_q];
    assign head_id   = fifo_id_q[head_q];

    // Back-to-back issue of the same upper PC would allocate two UPCT entries; one bubble lets
    // the earlier write land so the CAM hits instead.
    assign hazard = s1_valid_q && (head_upc == s1_upc_q);
    assign issue  = (count_q != '0) && !flush && !hazard;

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        s1_valid_d = issue;
        s1_id_d    = s1_id_q;
        s1_upc_d   = s1_upc_q;

        if (grant_valid) begin
            rr_ptr_d = grant_id + ID_W'(1);
            tail_d   = tail_q + PTR_W'(1);
        end
        if (issue) begin
            head_d   = head_q + PTR_W'(1);
            s1_id_d  = head_id;
            s1_upc_d = head_upc;
        end
        case ({grant_valid, issue})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (flush) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            s1_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rr_ptr_q   <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            s1_valid_q <= 1'b0;
            s1_id_q    <= '0;
            s1_upc_q   <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            s1_valid_q <= s1_valid_d;
            s1_id_q    <= s1_id_d;
            s1_upc_q   <= s1_upc_d;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by count/head/tail.
    always_ff @(posedge CLK) begin
        if (grant_valid) begin
            fifo_id_q[tail_q]  <= grant_id;
            fifo_upc_q[tail_q] <= grant_upc;
        end
    end

    assign update0_valid         = issue;
    assign update0_start_full_PC = issue ? {head_upc, LOW_W'(0)} : 32'h0;

    assign resp_valid      = s1_valid_q && !flush;
    assign resp_req_id     = s1_id_q;
    assign resp_upper_PC   = s1_upc_q;
    assign resp_upct_index = update1_upct_index;

endmodule

// File: tb/tb_upct_update_ctrl.sv
// Directed self-checking bench for upct_update_ctrl with a small CAM-style UPCT stub.

module tb_upct_update_ctrl;
    import core_types_pkg::*;

    localparam int unsigned NUM_REQ   = 2;
    localparam int unsigned UPW       = UPPER_PC_WIDTH;
    localparam int unsigned LUE       = LOG_UPCT_ENTRIES;
    localparam int unsigned N_ENTRIES = 1 << LUE;

    logic                    CLK = 1'b0;
    logic                    nRST = 1'b0;
    logic [NUM_REQ-1:0]      req_valid = '0;
    logic [NUM_REQ-1:0][31:0] req_start_full_PC = '0;
    logic [NUM_REQ-1:0]      req_ready;
    logic                    flush = 1'b0;
    logic                    update0_valid;
    logic [31:0]             update0_start_full_PC;
    logic [LUE-1:0]          update1_upct_index;
    logic                    resp_valid;
    logic                    resp_req_id;
    logic [UPW-1:0]          resp_upper_PC;
    logic [LUE-1:0]          resp_upct_index;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 CLK = ~CLK;

    upct_update_ctrl #(.NUM_REQ(2), .FIFO_DEPTH(4)) dut (
        .CLK                   (CLK),
        .nRST                  (nRST),
        .req_valid             (req_valid),
        .req_start_full_PC     (req_start_full_PC),
        .req_ready             (req_ready),
        .flush                 (flush),
        .update0_valid         (update0_valid),
        .update0_start_full_PC (update0_start_full_PC),
        .update1_upct_index    (update1_upct_index),
        .resp_valid            (resp_valid),
        .resp_req_id           (resp_req_id),
        .resp_upper_PC         (resp_upper_PC),
        .resp_upct_index       (resp_upct_index)
    );

    // UPCT stub: CAM lookup on update0, allocate on miss, index returned next cycle.
    logic [UPW-1:0]       cam_tag [N_ENTRIES];
    logic [N_ENTRIES-1:0] cam_v;
    logic [LUE-1:0]       alloc_ptr;
    logic [LUE-1:0]       idx_q;
    int                   alloc_cnt;
    logic                 hit;
    logic [LUE-1:0]       hit_idx;

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            if (!hit && cam_v[i] && cam_tag[i] == update0_start_full_PC[31 -: UPW]) begin
                hit     = 1'b1;
                hit_idx = LUE'(i);
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cam_v     <= '0;
            alloc_ptr <= '0;
            idx_q     <= '0;
            alloc_cnt <= 0;
        end else if (update0_valid) begin
            if (hit) begin
                idx_q <= hit_idx;
            end else begin
                cam_v[alloc_ptr]   <= 1'b1;
                cam_tag[alloc_ptr] <= update0_start_full_PC[31 -: UPW];
                idx_q              <= alloc_ptr;
                alloc_ptr          <= alloc_ptr + LUE'(1);
                alloc_cnt          <= alloc_cnt + 1;
            end
        end
    end

    assign update1_upct_index = idx_q;

    // Leaves the bench at the start of cycle 1 (just after a negedge) with reset released.
    task automatic do_reset;
        req_valid = '0;
        req_start_full_PC = '0;
        flush = 1'b0;
        nRST = 1'b0;
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic test_reset;
        req_valid = '0;
        flush = 1'b0;
        nRST = 1'b0;
        #1;
        n_checks++; if (update0_valid !== 1'b0) $display("FAIL rst_u0v got %b want 0", update0_valid); else n_pass++;
        n_checks++; if (update0_start_full_PC !== 32'h0) $display("FAIL rst_u0pc got %h want 0", update0_start_full_PC); else n_pass++;
        n_checks++; if (resp_valid !== 1'b0) $display("FAIL rst_rv got %b want 0", resp_valid); else n_pass++;
        n_checks++; if (resp_upper_PC !== '0) $display("FAIL rst_rupc got %h want 0", resp_upper_PC); else n_pass++;
        do_reset();
        #1;
        n_checks++; if (req_ready !== 2'b00) $display("FAIL rst_ready got %b want 00", req_ready); else n_pass++;
        n_checks++; if (resp_req_id !== 1'b0) $display("FAIL rst_rid got %b want 0", resp_req_id); else n_pass++;
    endtask

    task automatic test_single;
        do_reset();
        req_valid = 2'b01;
        req_start_full_PC[0] = 32'h8000_1234;
        #1;
        n_checks++; if (req_ready !== 2'b01) $display("FAIL single_ready got %b want 01", req_ready); else n_pass++;
        n_checks++; if (update0_valid !== 1'b0) $display("FAIL single_nobypass got %b want 0", update0_valid); else n_pass++;
        @(negedge CLK);
        req_valid = 2'b00;
        #1;
        n_checks++; if (update0_valid !== 1'b1) $display("FAIL single_u0v got %b want 1", update0_valid); else n_pass++;
        n_checks++; if (update0_start_full_PC !== 32'h8000_1000) $display("FAIL single_u0pc got %h want 80001000", update0_start_full_PC); else n_pass++;
        n_checks++; if (resp_valid !== 1'b0) $display("FAIL single_rv_early got %b want 0", resp_valid); else n_pass++;
        @(negedge CLK);
        #1;
        n_checks++; if (update0_valid !== 1'b0) $display("FAIL single_u0v_done got %b want 0", update0_valid); else n_pass++;
        n_checks++; if (resp_valid !== 1'b1) $display("FAIL single_rv got %b want 1", resp_valid); else n_pass++;
        n_checks++; if (resp_req_id !== 1'b0) $display("FAIL single_rid got %b want 0", resp_req_id); else n_pass++;
        n_checks++; if (resp_upper_PC !== 22'h200004) $display("FAIL single_rupc got %h want 200004", resp_upper_PC); else n_pass++;
        n_checks++; if (resp_upct_index !== 3'd0) $display("FAIL single_ridx got %0d want 0", resp_upct_index); else n_pass++;
        @(negedge CLK);
        #1;
        n_checks++; if (resp_valid !== 1'b0) $display("FAIL single_rv_after got %b want 0", resp_valid); else n_pass++;
    endtask

    task automatic test_rr;
        logic [1:0] exp_rdy [5] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
        do_reset();
        req_start_full_PC[0] = 32'h1000_0000;
        req_start_full_PC[1] = 32'h2000_0000;
        req_valid = 2'b11;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_checks++; if (req_ready !== exp_rdy[k]) $display("FAIL rr_grant c%0d got %b want %b", k + 1, req_ready, exp_rdy[k]); else n_pass++;
            if (k == 2) begin
                n_checks++; if (resp_valid !== 1'b1 || resp_req_id !== 1'b0) $display("FAIL rr_resp0 got v=%b id=%b want v=1 id=0", resp_valid, resp_req_id); else n_pass++;
            end
            if (k == 3) begin
                n_checks++; if (resp_valid !== 1'b1 || resp_upper_PC !== 22'h080000) $display("FAIL rr_resp1 got v=%b upc=%h want v=1 upc=080000", resp_valid, resp_upper_PC); else n_pass++;
            end
            @(negedge CLK);
        end
        req_valid = 2'b00;
    endtask

    // Same upper PC every cycle: issue rate halves, so the FIFO fills and must stall.
    task automatic test_backpressure;
        logic exp_rdy [10] = '{1, 1, 1, 1, 1, 1, 1, 0, 1, 0};
        logic exp_u0  [10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
        do_reset();
        req_start_full_PC[0] = 32'h4000_0000;
        req_valid = 2'b01;
        for (int k = 0; k < 10; k++) begin
            #1;
            n_checks++; if (req_ready[0] !== exp_rdy[k] || req_ready[1] !== 1'b0) $display("FAIL bp_ready c%0d got %b want 0%b", k + 1, req_ready, exp_rdy[k]); else n_pass++;
            n_checks++; if (update0_valid !== exp_u0[k]) $display("FAIL bp_u0v c%0d got %b want %b", k + 1, update0_valid, exp_u0[k]); else n_pass++;
            @(negedge CLK);
        end
        req_valid = 2'b00;
    endtask

    task automatic test_hazard;
        do_reset();
        req_start_full_PC[0] = 32'h1234_5678;
        req_start_full_PC[1] = 32'h1234_5678;
        req_valid = 2'b11;
        #1;
        n_checks++; if (req_ready !== 2'b01) $display("FAIL hz_grant0 got %b want 01", req_ready); else n_pass++;
        @(negedge CLK);
        req_valid = 2'b10;
        #1;
        n_checks++; if (req_ready !== 2'b10) $display("FAIL hz_grant1 got %b want 10", req_ready); else n_pass++;
        n_checks++; if (update0_valid !== 1'b1) $display("FAIL hz_issue0 got %b want 1", update0_valid); else n_pass++;
        @(negedge CLK);
        req_valid = 2'b00;
        #1;
        n_checks++; if (update0_valid !== 1'b0) $display("FAIL hz_bubble got %b want 0", update0_valid); else n_pass++;
        n_checks++; if (resp_valid !== 1'b1 || resp_req_id !== 1'b0 || resp_upct_index !== 3'd0) $display("FAIL hz_resp0 got v=%b id=%b idx=%0d want v=1 id=0 idx=0", resp_valid, resp_req_id, resp_upct_index); else n_pass++;
        @(negedge CLK);
        #1;
        n_checks++; if (update0_valid !== 1'b1 || update0_start_full_PC !== 32'h1234_5400) $display("FAIL hz_issue1 got v=%b pc=%h want v=1 pc=12345400", update0_valid, update0_start_full_PC); else n_pass++;
        n_checks++; if (resp_valid !== 1'b0) $display("FAIL hz_rv_gap got %b want 0", resp_valid); else n_pass++;
        @(negedge CLK);
        #1;
        n_checks++; if (resp_valid !== 1'b1 || resp_req_id !== 1'b1 || resp_upct_index !== 3'd0) $display("FAIL hz_resp1 got v=%b id=%b idx=%0d want v=1 id=1 idx=0", resp_valid, resp_req_id, resp_upct_index); else n_pass++;
        n_checks++; if (alloc_cnt !== 1) $display("FAIL hz_allocs got %0d want 1", alloc_cnt); else n_pass++;
    endtask

    task automatic test_flush;
        do_reset();
        req_start_full_PC[0] = 32'h4000_0000;
        req_valid = 2'b01;
        repeat (5) @(negedge CLK);
        #1;
        n_checks++; if (update0_valid !== 1'b1) $display("FAIL fl_pre_issue got %b want 1", update0_valid); else n_pass++;
        @(negedge CLK);
        flush = 1'b1;
        #1;
        n_checks++; if (req_ready !== 2'b00) $display("FAIL fl_ready got %b want 00", req_ready); else n_pass++;
        n_checks++; if (update0_valid !== 1'b0) $display("FAIL fl_u0v got %b want 0", update0_valid); else n_pass++;
        n_checks++; if (resp_valid !== 1'b0) $display("FAIL fl_rv got %b want 0", resp_valid); else n_pass++;
        @(negedge CLK);
        flush = 1'b0;
        req_valid = 2'b00;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++; if (update0_valid !== 1'b0 || resp_valid !== 1'b0) $display("FAIL fl_quiet c%0d got u0v=%b rv=%b want 0 0", k, update0_valid, resp_valid); else n_pass++;
            @(negedge CLK);
        end
        req_start_full_PC[0] = 32'h5000_0000;
        req_valid = 2'b01;
        #1;
        n_checks++; if (req_ready !== 2'b01) $display("FAIL fl_new_ready got %b want 01", req_ready); else n_pass++;
        @(negedge CLK);
        req_valid = 2'b00;
        #1;
        n_checks++; if (update0_valid !== 1'b1 || update0_start_full_PC !== 32'h5000_0000) $display("FAIL fl_new_issue got v=%b pc=%h want v=1 pc=50000000", update0_valid, update0_start_full_PC); else n_pass++;
        @(negedge CLK);
        #1;
        n_checks++; if (resp_valid !== 1'b1 || resp_upper_PC !== 22'h140000 || resp_upct_index !== 3'd1) $display("FAIL fl_new_resp got v=%b upc=%h idx=%0d want v=1 upc=140000 idx=1", resp_valid, resp_upper_PC, resp_upct_index); else n_pass++;
    endtask

    task automatic test_reset_mid;
        do_reset();
        req_start_full_PC[0] = 32'h4000_0000;
        req_valid = 2'b01;
        repeat (4) @(negedge CLK);
        #1;
        n_checks++; if (resp_valid !== 1'b1) $display("FAIL rm_pre_rv got %b want 1", resp_valid); else n_pass++;
        req_valid = 2'b00;
        nRST = 1'b0;
        #1;
        n_checks++; if (resp_valid !== 1'b0 || update0_valid !== 1'b0) $display("FAIL rm_valids got rv=%b u0v=%b want 0 0", resp_valid, update0_valid); else n_pass++;
        n_checks++; if (resp_upper_PC !== '0 || resp_req_id !== 1'b0) $display("FAIL rm_resp got upc=%h id=%b want 0 0", resp_upper_PC, resp_req_id); else n_pass++;
        n_checks++; if (update0_start_full_PC !== 32'h0 || req_ready !== 2'b00) $display("FAIL rm_u0 got pc=%h rdy=%b want 0 00", update0_start_full_PC, req_ready); else n_pass++;
        @(negedge CLK);
        nRST = 1'b1;
        req_start_full_PC[0] = 32'h6000_0000;
        req_start_full_PC[1] = 32'h7000_0000;
        req_valid = 2'b11;
        #1;
        n_checks++; if (req_ready !== 2'b01) $display("FAIL rm_first_grant got %b want 01", req_ready); else n_pass++;
        @(negedge CLK);
        #1;
        n_checks++; if (update0_valid !== 1'b1 || update0_start_full_PC !== 32'h6000_0000) $display("FAIL rm_first_issue got v=%b pc=%h want v=1 pc=60000000", update0_valid, update0_start_full_PC); else n_pass++;
        @(negedge CLK);
        req_valid = 2'b00;
    endtask

    initial begin
        test_reset();
        test_single();
        test_rr();
        test_backpressure();
        test_hazard();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
